// File: rtl/munoc_link_buffer_pkg.sv
// Shared link-format constants for the munoc link buffer: network type codes,
// link widths derived from the phit width, and a clog2 helper.
package munoc_link_buffer_pkg;

  localparam int NOT_SELECTED     = 0;
  localparam int FORWARD_NETWORK  = 1;
  localparam int BACKWARD_NETWORK = 2;

  // Forward links carry valid + last + phit; backward links carry valid + phit.
  function automatic int bw_fni_link(input int bw_phit);
    return bw_phit + 2;
  endfunction

  function automatic int bw_bni_link(input int bw_phit);
    return bw_phit + 1;
  endfunction

  function automatic int link_width(input int network_type, input int bw_phit);
    return (network_type == FORWARD_NETWORK) ? bw_fni_link(bw_phit) : bw_bni_link(bw_phit);
  endfunction

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/munoc_link_buffer_mem.sv
// DEPTH x W register array with one synchronous write port and one
// combinational read port.
module munoc_link_buffer_mem #(
  parameter int DEPTH   = 4,
  parameter int W       = 9,
  parameter int BW_ADDR = 2
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [BW_ADDR-1:0] wr_addr,
  input  logic [W-1:0]       wr_data,
  input  logic [BW_ADDR-1:0] rd_addr,
  output logic [W-1:0]       rd_data
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/munoc_link_buffer.sv
// In-order flit buffer in front of a router input port. Define
// MUNOC_LINK_BUFFER_BYPASS_EN for a zero-latency path when the buffer is empty.
module munoc_link_buffer
  import munoc_link_buffer_pkg::*;
#(
  parameter int NETWORK_TYPE = NOT_SELECTED,
  parameter int BW_PHIT      = 8,
  parameter int DEPTH        = 4,
  localparam int W           = link_width(NETWORK_TYPE, BW_PHIT),
  localparam int BW_PTR      = clog2(DEPTH),
  localparam int BW_OCC      = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              clear,
  output logic              input_ready,
  input  logic [W-1:0]      input_port,
  input  logic              output_ready,
  output logic [W-1:0]      output_port,
  output logic [BW_OCC-1:0] occupancy
);

  logic [BW_PTR-1:0] wr_ptr;
  logic [BW_PTR-1:0] rd_ptr;
  logic [W-1:0]      rd_data;
  logic              head_valid;
  logic              bypass;
  logic              push;
  logic              pop;

  // Ready comes from registered state only, so a pop never frees a slot for the same cycle.
  assign input_ready = (occupancy != BW_OCC'(DEPTH)) & ~clear & rstnn;
  assign head_valid  = (occupancy != '0) & ~clear & rstnn;

`ifdef MUNOC_LINK_BUFFER_BYPASS_EN
  assign bypass = (occupancy == '0) & ~clear & rstnn & input_port[W-1] & output_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push = input_port[W-1] & input_ready & ~bypass;
  assign pop  = head_valid & output_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    output_port = '0;
    if (head_valid)  output_port = rd_data;
    else if (bypass) output_port = input_port;
  end

  munoc_link_buffer_mem #(
    .DEPTH   (DEPTH),
    .W       (W),
    .BW_ADDR (BW_PTR)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (input_port),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rstnn || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
